// File: rtl/wall_bounce_tracker_if.sv
// Object position in, wall-contact flags and bounce requests out, for wall_bounce_tracker.
// The motion block drives the master side; the tracker implements the slave side.
interface wall_bounce_tracker_if #(
    parameter int W     = 10,
    parameter int CNT_W = 3
);
    logic             frame_tick;
    logic             arm;
    logic [W-1:0]     objectX;
    logic [W-1:0]     objectY;
    logic [W-1:0]     objectS;
    logic             isWallTop;
    logic             isWallBottom;
    logic             isWallLeft;
    logic             isWallRight;
    logic             bounce_x;
    logic             bounce_y;
    logic [CNT_W-1:0] bounce_count;
    logic             in_contact;
    logic             expired;

    modport master (
        output frame_tick, arm, objectX, objectY, objectS,
        input  isWallTop, isWallBottom, isWallLeft, isWallRight,
        input  bounce_x, bounce_y, bounce_count, in_contact, expired
    );

    modport slave (
        input  frame_tick, arm, objectX, objectY, objectS,
        output isWallTop, isWallBottom, isWallLeft, isWallRight,
        output bounce_x, bounce_y, bounce_count, in_contact, expired
    );
endinterface

// File: rtl/wall_bounce_tracker.sv
// Frame-synchronous arena-wall contact tracker: flags, per-axis bounce pulses, bounce count, expiry.
// Optional macro WALL_LEGACY_PRIORITY_EN: one flag per evaluation, priority bottom > top > left > right.
module wall_bounce_tracker #(
    parameter int W           = 10,
    parameter int LEFT        = 20,
    parameter int RIGHT       = 635,
    parameter int TOP         = 20,
    parameter int BOTTOM      = 470,
    parameter int MAX_BOUNCES = 5,
    parameter int CNT_W       = 3
) (
    input  logic                  Clk,
    input  logic                  Reset,
    wall_bounce_tracker_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FREE    = 2'd1,
        ST_CONTACT = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    localparam logic [W:0] LEFT_C   = (W+1)'(LEFT);
    localparam logic [W:0] RIGHT_C  = (W+1)'(RIGHT);
    localparam logic [W:0] TOP_C    = (W+1)'(TOP);
    localparam logic [W:0] BOTTOM_C = (W+1)'(BOTTOM);

    // Mask order {top, bottom, left, right}; W+1-bit sums so S > Y reads as top contact, not a wrap.
    function automatic logic [3:0] contact_mask(input logic [W-1:0] x, input logic [W-1:0] y,
                                                input logic [W-1:0] s);
        logic t, b, l, r;
        b = ({1'b0, y} + {1'b0, s}) >= BOTTOM_C;
        r = ({1'b0, x} + {1'b0, s}) >= RIGHT_C;
        t = {1'b0, y} <= (TOP_C + {1'b0, s});
        l = {1'b0, x} <= (LEFT_C + {1'b0, s});
`ifdef WALL_LEGACY_PRIORITY_EN
        if (b) begin
            contact_mask = 4'b0100;
        end else if (t) begin
            contact_mask = 4'b1000;
        end else if (l) begin
            contact_mask = 4'b0010;
        end else if (r) begin
            contact_mask = 4'b0001;
        end else begin
            contact_mask = 4'b0000;
        end
`else
        contact_mask = {t, b, l, r};
`endif
    endfunction

    state_t           state_q, state_d;
    logic [3:0]       flags_q, flags_d;
    logic             prev_x_q, prev_x_d;
    logic             prev_y_q, prev_y_d;
    logic             bounce_x_q, bounce_x_d;
    logic             bounce_y_q, bounce_y_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             in_contact_q, in_contact_d;
    logic             expired_q, expired_d;

    logic [3:0]       mask_s;
    logic             axis_x_s, axis_y_s, new_x_s, new_y_s, new_any_s;
    logic             eval_s, expire_s;
    logic [CNT_W:0]   count_inc_s;
    logic [CNT_W-1:0] count_sat_s;

    assign mask_s      = contact_mask(bus.objectX, bus.objectY, bus.objectS);
    assign axis_x_s    = mask_s[1] | mask_s[0];
    assign axis_y_s    = mask_s[3] | mask_s[2];
    assign new_x_s     = axis_x_s & ~prev_x_q;
    assign new_y_s     = axis_y_s & ~prev_y_q;
    assign new_any_s   = new_x_s | new_y_s;
    assign count_inc_s = {1'b0, count_q} + {{CNT_W{1'b0}}, 1'b1};
    assign count_sat_s = (&count_q) ? count_q : count_inc_s[CNT_W-1:0];
    assign expire_s    = (MAX_BOUNCES != 0) && (int'(count_inc_s) == MAX_BOUNCES);
    assign eval_s      = bus.frame_tick & ~bus.arm &
                         ((state_q == ST_FREE) || (state_q == ST_CONTACT));

    // Next-state and output decode; arm overrides any evaluation in the same cycle.
    always_comb begin
        state_d    = state_q;
        flags_d    = flags_q;
        prev_x_d   = prev_x_q;
        prev_y_d   = prev_y_q;
        bounce_x_d = 1'b0;
        bounce_y_d = 1'b0;
        count_d    = count_q;
        if (bus.arm) begin
            state_d  = ST_FREE;
            flags_d  = 4'b0000;
            prev_x_d = 1'b0;
            prev_y_d = 1'b0;
            count_d  = {CNT_W{1'b0}};
        end else if (eval_s) begin
            flags_d    = mask_s;
            prev_x_d   = axis_x_s;
            prev_y_d   = axis_y_s;
            bounce_x_d = new_x_s;
            bounce_y_d = new_y_s;
            if (new_any_s) begin
                count_d = count_sat_s;
                state_d = expire_s ? ST_EXPIRED : ST_CONTACT;
            end else if (axis_x_s | axis_y_s) begin
                state_d = state_q;
            end else begin
                state_d = ST_FREE;
            end
        end else begin
            state_d = state_q;
        end
        in_contact_d = (state_d == ST_CONTACT);
        expired_d    = (state_d == ST_EXPIRED);
    end

    // State and registered outputs.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            flags_q      <= 4'b0000;
            prev_x_q     <= 1'b0;
            prev_y_q     <= 1'b0;
            bounce_x_q   <= 1'b0;
            bounce_y_q   <= 1'b0;
            count_q      <= {CNT_W{1'b0}};
            in_contact_q <= 1'b0;
            expired_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            flags_q      <= flags_d;
            prev_x_q     <= prev_x_d;
            prev_y_q     <= prev_y_d;
            bounce_x_q   <= bounce_x_d;
            bounce_y_q   <= bounce_y_d;
            count_q      <= count_d;
            in_contact_q <= in_contact_d;
            expired_q    <= expired_d;
        end
    end

    assign bus.isWallTop    = flags_q[3];
    assign bus.isWallBottom = flags_q[2];
    assign bus.isWallLeft   = flags_q[1];
    assign bus.isWallRight  = flags_q[0];
    assign bus.bounce_x     = bounce_x_q;
    assign bus.bounce_y     = bounce_y_q;
    assign bus.bounce_count = count_q;
    assign bus.in_contact   = in_contact_q;
    assign bus.expired      = expired_q;

endmodule

// File: tb/tb_wall_bounce_tracker.sv
// Bench for wall_bounce_tracker: directed vector table, reset abort sequence, randomized run vs model.
module tb_wall_bounce_tracker;
    localparam int W = 10;
    localparam int CNT_W = 3;
    localparam int MAXB = 5;
`ifdef WALL_LEGACY_PRIORITY_EN
    localparam bit LEG = 1'b1;
`else
    localparam bit LEG = 1'b0;
`endif

    logic Clk;
    logic Reset;
    int   n_tests;
    int   n_fail;

    wall_bounce_tracker_if #(.W(W), .CNT_W(CNT_W)) bus ();

    wall_bounce_tracker #(.W(W), .MAX_BOUNCES(MAXB), .CNT_W(CNT_W)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic        a;
        logic        t;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [9:0]  s;
        logic [10:0] exp;
    } vec_t;

    vec_t tbl[$];

    // Reference model: tracking on/off, expiry, previous axis contacts and the visible outputs.
    bit       m_active, m_expired, m_px, m_py, m_bx, m_by, m_ic;
    int       m_cnt;
    bit [3:0] m_flags;

    function automatic logic [10:0] ex(input logic [3:0] f, input logic bx, input logic by,
                                       input int c, input logic ic, input logic e);
        logic [2:0] c3;
        c3 = c[2:0];
        return {f, bx, by, c3, ic, e};
    endfunction

    function automatic vec_t mk(input logic a, input logic t, input int x, input int y,
                                input int s, input logic [10:0] e);
        vec_t v;
        v.a = a; v.t = t; v.x = x[9:0]; v.y = y[9:0]; v.s = s[9:0]; v.exp = e;
        return v;
    endfunction

    function automatic logic [10:0] got();
        return {bus.isWallTop, bus.isWallBottom, bus.isWallLeft, bus.isWallRight,
                bus.bounce_x, bus.bounce_y, bus.bounce_count, bus.in_contact, bus.expired};
    endfunction

    task automatic model_reset();
        m_active = 0; m_expired = 0; m_px = 0; m_py = 0; m_bx = 0; m_by = 0; m_ic = 0;
        m_cnt = 0; m_flags = 4'b0000;
    endtask

    task automatic model_step(input bit a, input bit t, input int x, input int y, input int s);
        bit tp, bt, lf, rt, ax, ay;
        int inc;
        m_bx = 0; m_by = 0;
        if (a) begin
            m_active = 1; m_expired = 0; m_cnt = 0; m_flags = 4'b0000;
            m_px = 0; m_py = 0; m_ic = 0;
        end else if (t && m_active) begin
            bt = (y + s) >= 470;
            rt = (x + s) >= 635;
            tp = y <= (20 + s);
            lf = x <= (20 + s);
            if (LEG) begin
                if (bt) begin tp = 0; lf = 0; rt = 0; end
                else if (tp) begin lf = 0; rt = 0; end
                else if (lf) rt = 0;
            end
            m_flags = {tp, bt, lf, rt};
            ax = lf || rt;
            ay = tp || bt;
            m_bx = ax && !m_px;
            m_by = ay && !m_py;
            if (m_bx || m_by) begin
                inc = m_cnt + 1;
                if (MAXB != 0 && inc == MAXB) begin
                    m_expired = 1;
                    m_active = 0;
                end
                m_cnt = (inc > 7) ? 7 : inc;
            end
            m_px = ax;
            m_py = ay;
            m_ic = (ax || ay) && !m_expired;
        end
    endtask

    function automatic logic [10:0] model_out();
        return ex(m_flags, m_bx, m_by, m_cnt, m_ic, m_expired);
    endfunction

    task automatic check(input string name, input logic [10:0] exp);
        logic [10:0] g;
        g = got();
        n_tests++;
        if (g !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b required %b (flags tblr,bx,by,cnt,ic,exp)", name, g, exp);
        end
    endtask

    task automatic step(input logic a, input logic t, input int x, input int y, input int s);
        bus.arm = a;
        bus.frame_tick = t;
        bus.objectX = x[9:0];
        bus.objectY = y[9:0];
        bus.objectS = s[9:0];
        @(posedge Clk);
        #1;
        bus.arm = 1'b0;
        bus.frame_tick = 1'b0;
        model_step(a, t, x, y, s);
    endtask

    function automatic int pick(input int lo_max, input int hi_min, input int hi_max);
        int sel;
        sel = $urandom_range(0, 2);
        if (sel == 0) return $urandom_range(0, lo_max);
        else if (sel == 1) return $urandom_range(hi_min, hi_max);
        else return $urandom_range(0, hi_max);
    endfunction

    initial begin
        n_tests = 0;
        n_fail = 0;
        model_reset();
        bus.arm = 1'b0; bus.frame_tick = 1'b0;
        bus.objectX = '0; bus.objectY = '0; bus.objectS = '0;
        Reset = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        check("reset_state", 11'b0);
        Reset = 1'b0;

        tbl.push_back(mk(1, 0, 300, 465, 5, ex(4'b0000, 0, 0, 0, 0, 0)));
        tbl.push_back(mk(0, 1, 300, 465, 5, ex(4'b0100, 0, 1, 1, 1, 0)));
        tbl.push_back(mk(0, 0, 300, 465, 5, ex(4'b0100, 0, 0, 1, 1, 0)));
        tbl.push_back(mk(0, 1, 300, 465, 5, ex(4'b0100, 0, 0, 1, 1, 0)));
        tbl.push_back(mk(0, 1, 300, 300, 5, ex(4'b0000, 0, 0, 1, 0, 0)));
        tbl.push_back(mk(1, 0, 300, 300, 5, ex(4'b0000, 0, 0, 0, 0, 0)));
        tbl.push_back(mk(0, 1, 630, 15, 5, LEG ? ex(4'b1000, 0, 1, 1, 1, 0)
                                                : ex(4'b1001, 1, 1, 1, 1, 0)));
        tbl.push_back(mk(1, 0, 3, 200, 8, ex(4'b0000, 0, 0, 0, 0, 0)));
        tbl.push_back(mk(0, 1, 3, 200, 8, ex(4'b0010, 1, 0, 1, 1, 0)));
        tbl.push_back(mk(1, 1, 300, 465, 5, ex(4'b0000, 0, 0, 0, 0, 0)));
        tbl.push_back(mk(0, 1, 300, 465, 5, ex(4'b0100, 0, 1, 1, 1, 0)));
        tbl.push_back(mk(0, 1, 300, 300, 5, ex(4'b0000, 0, 0, 1, 0, 0)));
        tbl.push_back(mk(0, 1, 3, 200, 8, ex(4'b0010, 1, 0, 2, 1, 0)));
        tbl.push_back(mk(0, 1, 300, 300, 5, ex(4'b0000, 0, 0, 2, 0, 0)));
        tbl.push_back(mk(0, 1, 300, 465, 5, ex(4'b0100, 0, 1, 3, 1, 0)));
        tbl.push_back(mk(0, 1, 300, 300, 5, ex(4'b0000, 0, 0, 3, 0, 0)));
        tbl.push_back(mk(0, 1, 630, 15, 5, LEG ? ex(4'b1000, 0, 1, 4, 1, 0)
                                                : ex(4'b1001, 1, 1, 4, 1, 0)));
        tbl.push_back(mk(0, 1, 300, 300, 5, ex(4'b0000, 0, 0, 4, 0, 0)));
        tbl.push_back(mk(0, 1, 300, 465, 5, ex(4'b0100, 0, 1, 5, 0, 1)));
        tbl.push_back(mk(0, 1, 300, 300, 5, ex(4'b0100, 0, 0, 5, 0, 1)));
        tbl.push_back(mk(0, 1, 3, 200, 8, ex(4'b0100, 0, 0, 5, 0, 1)));
        tbl.push_back(mk(1, 0, 3, 200, 8, ex(4'b0000, 0, 0, 0, 0, 0)));
        tbl.push_back(mk(0, 1, 300, 465, 5, ex(4'b0100, 0, 1, 1, 1, 0)));
        tbl.push_back(mk(0, 1, 632, 467, 5, LEG ? ex(4'b0100, 0, 0, 1, 1, 0)
                                                 : ex(4'b0101, 1, 0, 2, 1, 0)));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].a, tbl[i].t, int'(tbl[i].x), int'(tbl[i].y), int'(tbl[i].s));
            check($sformatf("vec%0d", i), tbl[i].exp);
        end

        // Asynchronous abort while in CONTACT: outputs clear before any further clock edge.
        #3;
        Reset = 1'b1;
        #1;
        check("reset_async_abort", 11'b0);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        model_reset();
        step(0, 1, 300, 465, 5);
        check("idle_ignores_tick_a", 11'b0);
        step(0, 1, 630, 15, 5);
        check("idle_ignores_tick_b", 11'b0);

        step(1, 0, 300, 300, 5);
        check("rand_arm", model_out());
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 49) == 0), $urandom_range(0, 1),
                 pick(40, 600, 660), pick(40, 440, 500), $urandom_range(0, 20));
            check($sformatf("rand%0d", i), model_out());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
